os_array_ctrl: RTL and testbench
================================

Name: os_array_ctrl

Overview:
Tile sequencer for an ARRAY_N x ARRAY_N output-stationary MAC array built from os_pe cells. It accepts a tile command carrying the reduction depth and gates operand beats into the array edge. It waits for the skewed wavefront to finish, issues the one-cycle accumulator-to-shadow load/clear, then drains the shadow chain row by row under a valid/ready handshake.

Parameters:
ARRAY_N, 4, array rows = columns; drain beats per tile
K_W, 16, width of the reduction-depth field
SKEW_LAT, 2*(ARRAY_N-1), cycles from the last accepted edge beat to the last MAC in PE(N-1,N-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_vld  in  1  tile command valid
start_rdy  out  1  command accepted; high only in IDLE
k_len  in  K_W  reduction depth, sampled on start handshake
op_vld  in  1  operand row/col beat available at array edge
op_rdy  out  1  controller accepts beats (high in FEED)
din_row_en  out  1  edge MAC enable = op_vld & op_rdy; propagates through array
load_en  out  1  to all PEs: shadow <= acc, acc <= 0
shift_en  out  1  to all PEs: shadow chain shift one row
res_vld  out  1  bottom-row shadow data valid
res_rdy  in  1  downstream accepts result row
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, tile fully drained

Behaviour:
- Reset (async, any state, including mid-tile): state=IDLE, all counters 0. Outputs: start_rdy=1; op_rdy, din_row_en, load_en, shift_en, res_vld, busy and done all 0.
- States: IDLE, FEED, FLUSH, LOAD, DRAIN.
- IDLE: start_vld&start_rdy latches k_len into k_q. Next state is FEED if k_len!=0, else LOAD (emits an all-zero tile; accumulators are already clear).
- FEED: op_rdy=1. Each cycle with op_vld=1 increments beat_cnt and asserts din_row_en combinationally. op_vld=0 is a bubble: no count, din_row_en=0. When the accepted beat makes beat_cnt==k_q, next state is FLUSH.
- FLUSH: op_rdy=0. flush_cnt counts SKEW_LAT cycles, then next state is LOAD. SKEW_LAT=0 goes directly to LOAD.
- LOAD: exactly one cycle, load_en=1. Next state is DRAIN.
- DRAIN: res_vld=1.
  - res_vld&res_rdy: shift_en=1 in the same cycle, drain_cnt++.
  - res_rdy=0: hold; shift_en=0 and data stable.
  - After ARRAY_N handshakes, next state is IDLE and done=1 in that first IDLE cycle.
- No overlap: start_rdy=0 outside IDLE; start_vld there is ignored, not queued.
- load_en and shift_en are never high together. din_row_en is never high outside FEED.
- Counters: beat_cnt is K_W bits; flush_cnt is clog2(SKEW_LAT+1) bits; drain_cnt is clog2(ARRAY_N+1) bits. No wrap is reachable, since each counter clears on state exit.
- k_len=2^K_W-1 is legal; counts to max without overflow.
- Latency with no bubbles and res_rdy=1, start accepted at cycle 0:
  - FEED cycles 1..k
  - FLUSH k+1..k+SKEW_LAT
  - LOAD k+SKEW_LAT+1
  - DRAIN beats k+SKEW_LAT+2 .. k+SKEW_LAT+ARRAY_N+1
  - done at k+SKEW_LAT+ARRAY_N+2

Optional Feature:
OS_ARRAY_CTRL_PERF_EN
- Defined: adds outputs perf_bubble_cnt[31:0] (FEED cycles with op_vld=0), perf_stall_cnt[31:0] (DRAIN cycles with res_rdy=0) and perf_tile_cnt[31:0] (done pulses).
  - All three saturate at all-ones and reset to 0 on rst_n.
  - None is cleared by a new tile.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package os_array_pkg: state enum (IDLE/FEED/FLUSH/LOAD/DRAIN, 3-bit), default ARRAY_N, K_W and ACC_WIDTH constants, and the SKEW_LAT derivation function.
- One sub-module, os_hs_cnt: an up-counter with a terminal-count flag, instantiated for beat, flush and drain counting.
- FSM and output decode live in os_array_ctrl.

Test Plan:
- Basic tile: ARRAY_N=4, k_len=8, op_vld=1, res_rdy=1, start at cycle 0 → 8 din_row_en cycles (1..8), load_en at cycle 15, shift_en cycles 16..19, done at cycle 20.
- Bubbles and backpressure: k_len=3 with op_vld low on 2 FEED cycles, and res_rdy low for 3 DRAIN cycles → exactly 3 din_row_en pulses, res_vld held, no shift during the stalls, exactly 4 shift_en pulses, done once.
- Zero depth: k_len=0 → IDLE→LOAD→DRAIN, no din_row_en, 4 result beats, done.
- Busy command: start_vld pulsed during FEED and DRAIN → start_rdy=0, ignored; exactly one done. A second start immediately after done is accepted.
- Reset mid-DRAIN: rst_n low after 2 shift handshakes → all outputs at reset values in the same cycle; a following k_len=2 tile completes normally with 4 drain beats.
- PERF_EN build: a tile with 2 bubbles and 3 stalls → perf_bubble_cnt=2, perf_stall_cnt=3, perf_tile_cnt=1.

Source files
------------

// File: rtl/os_array_pkg.sv
// Shared types and defaults for the output-stationary array tile sequencer.
package os_array_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        FLUSH = 3'd2,
        LOAD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int DEF_ARRAY_N   = 4;
    localparam int DEF_K_W       = 16;
    localparam int DEF_ACC_WIDTH = 32;

    // Wavefront skew: the last edge beat reaches PE(N-1,N-1) after N-1 row plus N-1 column hops.
    function automatic int skew_lat(input int n);
        return 2 * (n - 1);
    endfunction

endpackage

// File: rtl/os_hs_cnt.sv
// Up-counter with a terminal-count flag; it self-clears on the increment that reaches term.
module os_hs_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         hit
);

    logic [W-1:0] cnt;

    // Compare one bit wider so that a term of all-ones never wraps.
    assign hit = inc && (({1'b0, cnt} + (W+1)'(1)) == {1'b0, term});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= hit ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/os_array_ctrl.sv
// Tile sequencer for the output-stationary MAC array: feed, flush the skew, load shadows, drain rows.
// Optional performance counters are enabled by defining OS_ARRAY_CTRL_PERF_EN.
module os_array_ctrl
    import os_array_pkg::*;
#(
    parameter int ARRAY_N  = DEF_ARRAY_N,
    parameter int K_W      = DEF_K_W,
    parameter int SKEW_LAT = skew_lat(ARRAY_N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_vld,
    output logic           start_rdy,
    input  logic [K_W-1:0] k_len,
    input  logic           op_vld,
    output logic           op_rdy,
    output logic           din_row_en,
    output logic           load_en,
    output logic           shift_en,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic           busy,
    output logic           done
`ifdef OS_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]    perf_bubble_cnt,
    output logic [31:0]    perf_stall_cnt,
    output logic [31:0]    perf_tile_cnt
`endif
);

    localparam int FW = (SKEW_LAT > 0) ? $clog2(SKEW_LAT + 1) : 1;
    localparam int DW = $clog2(ARRAY_N + 1);

    state_t         state;
    state_t         next_state;
    logic [K_W-1:0] k_q;
    logic           done_q;
    logic           beat_hit;
    logic           flush_hit;
    logic           drain_hit;

    os_hs_cnt #(.W(K_W)) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == FEED) && op_vld),
        .term  (k_q),
        .hit   (beat_hit)
    );

    os_hs_cnt #(.W(FW)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state == FLUSH),
        .term  (FW'(SKEW_LAT)),
        .hit   (flush_hit)
    );

    os_hs_cnt #(.W(DW)) u_drain_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   ((state == DRAIN) && res_rdy),
        .term  (DW'(ARRAY_N)),
        .hit   (drain_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            k_q    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= (state == DRAIN) && drain_hit;
            if ((state == IDLE) && start_vld) begin
                k_q <= k_len;
            end
        end
    end

    // A zero-depth tile skips straight to LOAD: the accumulators are already clear.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_vld) next_state = (k_len != '0) ? FEED : LOAD;
            FEED:    if (beat_hit)  next_state = (SKEW_LAT == 0) ? LOAD : FLUSH;
            FLUSH:   if (flush_hit) next_state = LOAD;
            LOAD:    next_state = DRAIN;
            DRAIN:   if (drain_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start_rdy  = (state == IDLE);
        op_rdy     = (state == FEED);
        din_row_en = (state == FEED) && op_vld;
        load_en    = (state == LOAD);
        res_vld    = (state == DRAIN);
        shift_en   = (state == DRAIN) && res_rdy;
        busy       = (state != IDLE);
        done       = done_q;
    end

`ifdef OS_ARRAY_CTRL_PERF_EN
    // Tile count advances on the final drain beat so it is current when done rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt <= '0;
            perf_stall_cnt  <= '0;
            perf_tile_cnt   <= '0;
        end else begin
            if ((state == FEED) && !op_vld && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
            end
            if ((state == DRAIN) && !res_rdy && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if ((state == DRAIN) && drain_hit && (perf_tile_cnt != '1)) begin
                perf_tile_cnt <= perf_tile_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_os_array_ctrl.sv
// Directed bench for os_array_ctrl: a tile table plus hand sequences for reset and back-to-back starts.
// Also checks the perf counters when OS_ARRAY_CTRL_PERF_EN is defined.
module tb_os_array_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_vld = 1'b0;
    logic [15:0] k_len = 16'd0;
    logic        op_vld = 1'b0;
    logic        res_rdy = 1'b0;
    logic        start_rdy;
    logic        op_rdy;
    logic        din_row_en;
    logic        load_en;
    logic        shift_en;
    logic        res_vld;
    logic        busy;
    logic        done;
`ifdef OS_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_tile_cnt;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    os_array_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_vld  (start_vld),
        .start_rdy  (start_rdy),
        .k_len      (k_len),
        .op_vld     (op_vld),
        .op_rdy     (op_rdy),
        .din_row_en (din_row_en),
        .load_en    (load_en),
        .shift_en   (shift_en),
        .res_vld    (res_vld),
        .res_rdy    (res_rdy),
        .busy       (busy),
        .done       (done)
`ifdef OS_ARRAY_CTRL_PERF_EN
        ,
        .perf_bubble_cnt (perf_bubble_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_tile_cnt   (perf_tile_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Bubbles occupy the first FEED cycles, stalls the first DRAIN cycles; cycles count from the start handshake.
    typedef struct {
        int k;
        int bubbles;
        int stalls;
        bit poke;
        int exp_din;
        int exp_load;
        int exp_shift;
        int exp_done;
    } vec_t;

    task automatic check_output(input string name, input longint actual, input longint expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " start_rdy"},  longint'(start_rdy),  1);
        check_output({tag, " op_rdy"},     longint'(op_rdy),     0);
        check_output({tag, " din_row_en"}, longint'(din_row_en), 0);
        check_output({tag, " load_en"},    longint'(load_en),    0);
        check_output({tag, " shift_en"},   longint'(shift_en),   0);
        check_output({tag, " res_vld"},    longint'(res_vld),    0);
        check_output({tag, " busy"},       longint'(busy),       0);
        check_output({tag, " done"},       longint'(done),       0);
`ifdef OS_ARRAY_CTRL_PERF_EN
        check_output({tag, " perf_bubble"}, longint'(perf_bubble_cnt), 0);
        check_output({tag, " perf_stall"},  longint'(perf_stall_cnt),  0);
        check_output({tag, " perf_tile"},   longint'(perf_tile_cnt),   0);
`endif
    endtask

    // Called mid-cycle while the DUT idles; returns mid-cycle in the done cycle.
    task automatic apply_stimulus(input vec_t v, input string tag);
        int din_n    = 0;
        int shift_n  = 0;
        int load_cyc = -1;
        int done_cyc = -1;
        int bub      = 0;
        int stl      = 0;
        int viol     = 0;
        int limit    = v.k + v.bubbles + v.stalls + 40;
        check_output({tag, " start_rdy"}, longint'(start_rdy), 1);
        start_vld = 1'b1;
        k_len     = 16'(v.k);
        @(posedge clk);
        for (int cyc = 1; cyc <= limit && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start_vld = 1'b0;
            op_vld    = (bub >= v.bubbles);
            if (op_rdy && !op_vld) bub++;
            res_rdy   = !(res_vld && (stl < v.stalls));
            if (res_vld && !res_rdy) stl++;
            if (v.poke && (op_rdy || res_vld)) begin
                start_vld = 1'b1;
                k_len     = 16'd5;
            end
            #1;
            if (start_vld && start_rdy) viol++;
            if (din_row_en !== (op_vld & op_rdy)) viol++;
            if (shift_en !== (res_vld & res_rdy)) viol++;
            if (load_en && shift_en) viol++;
            if (busy !== !start_rdy) viol++;
            if (din_row_en) din_n++;
            if (shift_en) shift_n++;
            if (load_en && load_cyc < 0) load_cyc = cyc;
            if (done) done_cyc = cyc;
        end
        start_vld = 1'b0;
        check_output({tag, " din pulses"},   din_n,    v.exp_din);
        check_output({tag, " load cycle"},   load_cyc, v.exp_load);
        check_output({tag, " shift pulses"}, shift_n,  v.exp_shift);
        check_output({tag, " done cycle"},   done_cyc, v.exp_done);
        check_output({tag, " protocol"},     viol,     0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t post_rst;
        int   shifts;
        int   sum_bub = 0;
        int   sum_stl = 0;

        vecs[0] = '{8,     0, 0, 1'b0, 8,     15,    4, 20};
        vecs[1] = '{3,     2, 3, 1'b0, 3,     12,    4, 20};
        vecs[2] = '{0,     0, 0, 1'b0, 0,     1,     4, 6};
        vecs[3] = '{1,     0, 0, 1'b1, 1,     8,     4, 13};
        vecs[4] = '{2,     1, 1, 1'b1, 2,     10,    4, 16};
        vecs[5] = '{65535, 0, 0, 1'b0, 65535, 65542, 4, 65547};
        post_rst = '{2,    2, 3, 1'b0, 2,     11,    4, 19};

        op_vld  = 1'b1;
        res_rdy = 1'b1;
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Each tile starts in the done cycle of the previous one, so back-to-back acceptance is exercised too.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
            sum_bub += vecs[i].bubbles;
            sum_stl += vecs[i].stalls;
        end
`ifdef OS_ARRAY_CTRL_PERF_EN
        check_output("perf bubbles total", longint'(perf_bubble_cnt), sum_bub);
        check_output("perf stalls total",  longint'(perf_stall_cnt),  sum_stl);
        check_output("perf tiles total",   longint'(perf_tile_cnt),   6);
`endif

        // Reset arriving mid-DRAIN after two result handshakes.
        start_vld = 1'b1;
        k_len     = 16'd4;
        @(posedge clk);
        shifts = 0;
        for (int cyc = 0; cyc < 60 && shifts < 2; cyc++) begin
            @(negedge clk);
            start_vld = 1'b0;
            op_vld    = 1'b1;
            res_rdy   = 1'b1;
            #1;
            if (shift_en) shifts++;
        end
        check_output("mid-drain shifts", shifts, 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(post_rst, "post-reset");
`ifdef OS_ARRAY_CTRL_PERF_EN
        check_output("perf bubbles", longint'(perf_bubble_cnt), 2);
        check_output("perf stalls",  longint'(perf_stall_cnt),  3);
        check_output("perf tiles",   longint'(perf_tile_cnt),   1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
